// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Display back end of the frequency counter. Captures a BCD tens/units pair
//   on a load strobe, decodes the selected digit to seven-segment form and
//   time-multiplexes both digits onto one shared segment bus.
//
//   Parameters:
//     REFRESH_CYCLES  clocks each digit stays selected (1..65535)
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous, active-high
//     load        one-cycle strobe, captures ten_count/unit_count
//     ten_count   tens BCD value
//     unit_count  units BCD value
//     segments    {g,f,e,d,c,b,a}, active-high, registered
//     digit       0 = units selected, 1 = tens selected, registered
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, the tens display is dark while its value is zero.

module seven_segment_mux #(
  parameter int unsigned REFRESH_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  localparam int unsigned RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_CYCLES - 1);

  logic [3:0]      tens_q;
  logic [3:0]      units_q;
  logic [RC_W-1:0] rc;

  logic [3:0]      tens_d;
  logic [3:0]      units_d;
  logic [RC_W-1:0] rc_d;
  logic            digit_d;
  logic            wrap;
  logic [6:0]      segments_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Segments are decoded from the post-edge values of the digit select and
  // digit registers, so the bus always matches the digit being driven.
  always_comb begin
    tens_d  = load ? ten_count  : tens_q;
    units_d = load ? unit_count : units_q;
    wrap    = (rc == RC_MAX);
    rc_d    = wrap ? '0 : rc + 1'b1;
    digit_d = wrap ? ~digit : digit;
`ifdef LEADING_ZERO_BLANK_EN
    if (digit_d && (tens_d == 4'd0))
      segments_d = '0;
    else
      segments_d = decode(digit_d ? tens_d : units_d);
`else
    segments_d = decode(digit_d ? tens_d : units_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q   <= '0;
      units_q  <= '0;
      rc       <= '0;
      digit    <= 1'b0;
      segments <= 7'h3F;
    end else begin
      tens_q   <= tens_d;
      units_q  <= units_d;
      rc       <= rc_d;
      digit    <= digit_d;
      segments <= segments_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ten_count = '0;
  logic [3:0] unit_count = '0;
  logic [6:0] segments4, segments1;
  logic       digit4, digit1;

  int compared = 0;
  int mismatched = 0;

  // reference state: edges since last reset and last captured pair
  int unsigned n = 0;
  int unsigned m_tens = 0;
  int unsigned m_units = 0;

  localparam logic [6:0] SEG_TBL [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_mux #(.REFRESH_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .ten_count(ten_count),
    .unit_count(unit_count), .segments(segments4), .digit(digit4));

  seven_segment_mux #(.REFRESH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .ten_count(ten_count),
    .unit_count(unit_count), .segments(segments1), .digit(digit1));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input int unsigned dig, input int unsigned t,
                                         input int unsigned u);
    int unsigned v;
    v = (dig != 0) ? t : u;
`ifdef LEADING_ZERO_BLANK_EN
    if (dig != 0 && t == 0) return 7'h00;
`endif
    if (v > 9) return 7'h40;
    return SEG_TBL[v];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input logic r, input logic l, input logic [3:0] t, input logic [3:0] u);
    int unsigned d4, d1;
    @(negedge clk);
    reset = r; load = l; ten_count = t; unit_count = u;
    @(posedge clk);
    if (r) begin
      n = 0; m_tens = 0; m_units = 0;
    end else begin
      if (l) begin m_tens = t; m_units = u; end
      n++;
    end
    #1;
    d4 = (n / 4) % 2;
    d1 = n % 2;
    check("digit_r4", {7'b0, digit4}, 8'(d4));
    check("seg_r4", {1'b0, segments4}, {1'b0, ref_seg(d4, m_tens, m_units)});
    check("digit_r1", {7'b0, digit1}, 8'(d1));
    check("seg_r1", {1'b0, segments1}, {1'b0, ref_seg(d1, m_tens, m_units)});
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    // reset held two cycles
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd9, 4'd9);
    check("reset_seg", {1'b0, segments4}, 8'h3F);
    check("reset_digit", {7'b0, digit4}, 8'h00);

    // load 4/2 with units selected
    step(1'b0, 1'b1, 4'd4, 4'd2);
    check("load42_units", {1'b0, segments4}, 8'h5B);
    idle(3);
    check("load42_tens", {1'b0, segments4}, 8'h66);
    check("load42_tens_digit", {7'b0, digit4}, 8'h01);
    idle(4);
    check("load42_units_again", {1'b0, segments4}, 8'h5B);

    // load coincident with units->tens toggle (n goes 11 -> 12)
    idle(3);
    step(1'b0, 1'b1, 4'd7, 4'd9);
    check("coincident_seg", {1'b0, segments4}, 8'h07);
    check("coincident_digit", {7'b0, digit4}, 8'h01);
    idle(4);

    // out-of-range codes
    step(1'b0, 1'b1, 4'd12, 4'd15);
    check("oor_seg", {1'b0, segments4}, 8'h40);
    idle(8);

    // leading zero
    step(1'b0, 1'b1, 4'd0, 4'd5);
    idle(8);

    // back-to-back strobes: last wins
    step(1'b0, 1'b1, 4'd1, 4'd3);
    step(1'b0, 1'b1, 4'd6, 4'd2);
    idle(6);

    // reset mid-frame after 8/8
    step(1'b0, 1'b1, 4'd8, 4'd8);
    idle(2);
    step(1'b1, 1'b1, 4'd3, 4'd3);
    check("midreset_seg", {1'b0, segments4}, 8'h3F);
    check("midreset_digit", {7'b0, digit4}, 8'h00);
    idle(5);

    // randomized traffic
    for (int unsigned i = 0; i < 400; i++)
      step($urandom_range(39) == 0, $urandom_range(3) == 0, 4'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Display back end of the frequency counter. Captures the BCD tens/units pair from the measurement core when `load` pulses, decodes the selected digit to seven-segment form, and time-multiplexes the two digits onto one shared segment bus plus one digit-select line. Sits directly downstream of the counter core and drives the board pins.

## Interface

- `REFRESH_CYCLES`, default 100: clocks each digit stays selected before `digit` toggles; legal range 1..65535.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: one-cycle strobe; capture `ten_count`/`unit_count` this edge.
- `ten_count` in 4: tens BCD value, sampled only when `load`=1.
- `unit_count` in 4: units BCD value, sampled only when `load`=1.
- `segments` out 7: {g,f,e,d,c,b,a}, active-high, registered.
- `digit` out 1: 0 = units display selected, 1 = tens display selected; registered.

## Operation

- State: `tens_q[3:0]`, `units_q[3:0]`, refresh counter `rc` (width clog2(REFRESH_CYCLES), min 1 bit), `digit` register, `segments` register.
- Capture: `load`=1 -> `tens_q`<=`ten_count`, `units_q`<=`unit_count`. `load`=0 -> hold. No handshake back to source; every strobe is accepted.
- Refresh: `rc` counts 0..REFRESH_CYCLES-1, wraps to 0; on the wrap edge `digit` toggles. REFRESH_CYCLES=1 -> `digit` toggles every clock.
- Decode (active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; 10..15 -> 40 (dash, segment g only).
- `segments` is loaded every edge with decode(next `digit` ? next `tens_q` : next `units_q`), i.e. from post-edge register values, so `segments` and `digit` are always mutually consistent.
- Reset: `tens_q`=0, `units_q`=0, `rc`=0, `digit`=0, `segments`=7'h3F.

## Timing

- Load to pin: new value visible on `segments` the edge after `load` is sampled, if the matching digit is selected; otherwise at the next toggle.
- Digit period: exactly REFRESH_CYCLES clocks per digit, 2×REFRESH_CYCLES per full frame; `load` never disturbs `rc` or `digit`.
- Simultaneous `load` and digit toggle on one edge: `segments` shows the newly loaded value for the newly selected digit.
- Back-to-back `load` strobes: last one wins; no loss of the current frame timing.
- `reset` asserted mid-frame: all state returns to reset values on that edge; `load` ignored while `reset`=1.
- No combinational path from any input to any output.

## Configuration

- `LEADING_ZERO_BLANK_EN` defined: when `digit`=1 and `tens_q`=0, `segments` = 7'h00 (tens display dark); units digit always shown, so value 0 displays as single "0". Reset output unchanged (7'h3F, units selected).
- Undefined: tens digit always decoded normally; 0 shows as "00".

## Test plan

- Reset: hold `reset` 2 cycles -> `digit`=0, `segments`=3F; REFRESH_CYCLES=4 -> `digit` toggles exactly every 4 clocks after release.
- Load 4/2 (`ten_count`=4, `unit_count`=2) while units selected -> next edge `segments`=5B; after toggle `digit`=1, `segments`=66; alternates 5B/66 each 4 clocks.
- Load coincident with toggle edge, 7/9 going units->tens -> that edge `segments`=07, `digit`=1.
- Out-of-range: load 12/15 -> both digits show 40.
- Blanking: load 0/5 -> with LEADING_ZERO_BLANK_EN tens phase 00, units phase 6D; without it tens phase 3F.
- Reset mid-frame after loading 8/8 -> next edge `segments`=3F, `digit`=0, `rc` restarted; REFRESH_CYCLES=1 -> `digit` toggles every clock.
